// File: rtl/dcache_inject_pkg.sv
// Shared types and geometry for the dcache checkpoint injector.
package dcache_inject_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAG,
    ST_DATA,
    ST_DONE
  } inj_state_t;

  localparam int unsigned TAG_BEATS   = 256;
  localparam int unsigned DATA_BEATS  = 2048;
  localparam int unsigned TOTAL_BEATS = TAG_BEATS + DATA_BEATS;

  localparam int unsigned TAG_ADDR_W   = 6;
  localparam int unsigned DATA_ADDR_W  = 9;
  localparam int unsigned TAG_WDATA_W  = 88;
  localparam int unsigned DATA_WDATA_W = 256;
  localparam int unsigned TAG_WMASK_W  = 4;
  localparam int unsigned DATA_WMASK_W = 32;

endpackage

// File: rtl/dcache_inject_port_mux.sv
// 2:1 SRAM RW0 port mux: dcache requests or injector writes (always write mode).
module dcache_inject_port_mux #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 88,
  parameter int unsigned MW = 4
) (
  input  logic          i_sel_inj,
  input  logic [AW-1:0] i_cache_addr,
  input  logic          i_cache_en,
  input  logic          i_cache_wmode,
  input  logic [DW-1:0] i_cache_wdata,
  input  logic [MW-1:0] i_cache_wmask,
  input  logic [AW-1:0] i_inj_addr,
  input  logic          i_inj_en,
  input  logic [DW-1:0] i_inj_wdata,
  input  logic [MW-1:0] i_inj_wmask,
  output logic [AW-1:0] o_addr,
  output logic          o_en,
  output logic          o_wmode,
  output logic [DW-1:0] o_wdata,
  output logic [MW-1:0] o_wmask
);

  always_comb begin
    o_addr  = i_cache_addr;
    o_en    = i_cache_en;
    o_wmode = i_cache_wmode;
    o_wdata = i_cache_wdata;
    o_wmask = i_cache_wmask;
    if (i_sel_inj) begin
      o_addr  = i_inj_addr;
      o_en    = i_inj_en;
      o_wmode = 1'b1;
      o_wdata = i_inj_wdata;
      o_wmask = i_inj_wmask;
    end
  end

endmodule

// File: rtl/dcache_inject_ctrl.sv
// Loads a warmup checkpoint into the L1 dcache tag/data SRAMs via their RW0 ports.
// Optional checksum accumulator: define DCACHE_INJECT_CHECKSUM_EN.
module dcache_inject_ctrl
  import dcache_inject_pkg::*;
#(
  parameter int unsigned SETS         = 64,
  parameter int unsigned WAYS         = 4,
  parameter int unsigned ROWS_PER_SET = 8,
  parameter int unsigned TAG_BITS     = 22,
  parameter int unsigned ROW_BITS     = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROW_BITS-1:0]     in_data,
  input  logic                    in_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    core_hold,
  output logic [ROW_BITS-1:0]     checksum,
  input  logic [TAG_ADDR_W-1:0]   cache_tag_addr,
  input  logic                    cache_tag_en,
  input  logic                    cache_tag_wmode,
  input  logic [TAG_WDATA_W-1:0]  cache_tag_wdata,
  input  logic [TAG_WMASK_W-1:0]  cache_tag_wmask,
  input  logic [DATA_ADDR_W-1:0]  cache_data_addr,
  input  logic                    cache_data_en,
  input  logic                    cache_data_wmode,
  input  logic [DATA_WDATA_W-1:0] cache_data_wdata,
  input  logic [DATA_WMASK_W-1:0] cache_data_wmask,
  output logic [TAG_ADDR_W-1:0]   tag_RW0_addr,
  output logic                    tag_RW0_en,
  output logic                    tag_RW0_wmode,
  output logic [TAG_WDATA_W-1:0]  tag_RW0_wdata,
  output logic [TAG_WMASK_W-1:0]  tag_RW0_wmask,
  output logic [DATA_ADDR_W-1:0]  data_RW0_addr,
  output logic                    data_RW0_en,
  output logic                    data_RW0_wmode,
  output logic [DATA_WDATA_W-1:0] data_RW0_wdata,
  output logic [DATA_WMASK_W-1:0] data_RW0_wmask
);

  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned BEAT_W = $clog2(TOTAL_BEATS + 1);
  localparam logic [WAY_W-1:0]  LAST_WAY      = WAY_W'(WAYS - 1);
  localparam logic [BEAT_W-1:0] LAST_TAG_BEAT = BEAT_W'(SETS * WAYS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT     = BEAT_W'(SETS * WAYS * (ROWS_PER_SET + 1) - 1);

  inj_state_t               r_state, w_state_nxt;
  logic [BEAT_W-1:0]        r_beat;
  logic [WAY_W-1:0]         r_way;
  logic [DATA_ADDR_W-1:0]   r_row;
  logic                     r_err;
  logic                     r_tag_wen, r_data_wen;
  logic [TAG_ADDR_W-1:0]    r_tag_addr;
  logic [TAG_WDATA_W-1:0]   r_tag_wdata;
  logic [TAG_WMASK_W-1:0]   r_tag_wmask;
  logic [DATA_ADDR_W-1:0]   r_data_addr;
  logic [DATA_WDATA_W-1:0]  r_data_wdata;
  logic [DATA_WMASK_W-1:0]  r_data_wmask;

  logic w_busy, w_acc, w_start_ok, w_is_last, w_sel_inj;

  assign w_busy     = (r_state == ST_TAG) || (r_state == ST_DATA);
  assign w_acc      = in_valid && w_busy;
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_is_last  = (r_beat == LAST_BEAT);
  // Keep the injector on the ports one extra cycle so the final registered write lands.
  assign w_sel_inj  = w_busy || r_tag_wen || r_data_wen;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: if (w_start_ok) w_state_nxt = ST_TAG;
      ST_TAG:           if (w_acc && r_beat == LAST_TAG_BEAT) w_state_nxt = ST_DATA;
      ST_DATA:          if (w_acc && w_is_last) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_way        <= '0;
      r_row        <= '0;
      r_err        <= 1'b0;
      r_tag_wen    <= 1'b0;
      r_data_wen   <= 1'b0;
      r_tag_addr   <= '0;
      r_tag_wdata  <= '0;
      r_tag_wmask  <= '0;
      r_data_addr  <= '0;
      r_data_wdata <= '0;
      r_data_wmask <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tag_wen  <= w_acc && (r_state == ST_TAG);
      r_data_wen <= w_acc && (r_state == ST_DATA);
      if (w_start_ok) begin
        r_beat <= '0;
        r_way  <= '0;
        r_row  <= '0;
        r_err  <= 1'b0;
      end else if (w_acc) begin
        r_beat <= r_beat + 1'b1;
        r_way  <= (r_way == LAST_WAY) ? '0 : r_way + 1'b1;
        if (r_way == LAST_WAY)
          r_row <= (r_beat == LAST_TAG_BEAT) ? '0 : r_row + 1'b1;
        if (in_last != w_is_last)
          r_err <= 1'b1;
      end
      if (w_acc) begin
        r_tag_addr   <= r_row[TAG_ADDR_W-1:0];
        r_tag_wdata  <= {WAYS{in_data[TAG_BITS-1:0]}};
        r_tag_wmask  <= TAG_WMASK_W'(1) << r_way;
        r_data_addr  <= r_row;
        r_data_wdata <= {WAYS{in_data}};
        r_data_wmask <= DATA_WMASK_W'(8'hFF) << {r_way, 3'b000};
      end
    end
  end

`ifdef DCACHE_INJECT_CHECKSUM_EN
  logic [ROW_BITS-1:0] r_checksum;
  always_ff @(posedge clk) begin
    if (reset || w_start_ok)
      r_checksum <= '0;
    else if (w_acc)
      r_checksum <= r_checksum ^ ((r_state == ST_TAG) ? ROW_BITS'(in_data[TAG_BITS-1:0]) : in_data);
  end
  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign in_ready  = w_busy;
  assign busy      = w_busy;
  assign core_hold = w_busy;
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;

  dcache_inject_port_mux #(.AW(TAG_ADDR_W), .DW(TAG_WDATA_W), .MW(TAG_WMASK_W)) u_tag_mux (
    .i_sel_inj     (w_sel_inj),
    .i_cache_addr  (cache_tag_addr),
    .i_cache_en    (cache_tag_en),
    .i_cache_wmode (cache_tag_wmode),
    .i_cache_wdata (cache_tag_wdata),
    .i_cache_wmask (cache_tag_wmask),
    .i_inj_addr    (r_tag_addr),
    .i_inj_en      (r_tag_wen),
    .i_inj_wdata   (r_tag_wdata),
    .i_inj_wmask   (r_tag_wmask),
    .o_addr        (tag_RW0_addr),
    .o_en          (tag_RW0_en),
    .o_wmode       (tag_RW0_wmode),
    .o_wdata       (tag_RW0_wdata),
    .o_wmask       (tag_RW0_wmask)
  );

  dcache_inject_port_mux #(.AW(DATA_ADDR_W), .DW(DATA_WDATA_W), .MW(DATA_WMASK_W)) u_data_mux (
    .i_sel_inj     (w_sel_inj),
    .i_cache_addr  (cache_data_addr),
    .i_cache_en    (cache_data_en),
    .i_cache_wmode (cache_data_wmode),
    .i_cache_wdata (cache_data_wdata),
    .i_cache_wmask (cache_data_wmask),
    .i_inj_addr    (r_data_addr),
    .i_inj_en      (r_data_wen),
    .i_inj_wdata   (r_data_wdata),
    .i_inj_wmask   (r_data_wmask),
    .o_addr        (data_RW0_addr),
    .o_en          (data_RW0_en),
    .o_wmode       (data_RW0_wmode),
    .o_wdata       (data_RW0_wdata),
    .o_wmask       (data_RW0_wmask)
  );

endmodule

// File: tb/tb_dcache_inject_ctrl.sv
// Self-checking bench for dcache_inject_ctrl against a beat-index reference model.
module tb_dcache_inject_ctrl;

  logic         clk = 1'b0;
  logic         reset, start, in_valid, in_last;
  logic [63:0]  in_data;
  logic         in_ready, busy, done, err, core_hold;
  logic [63:0]  checksum;
  logic [5:0]   cache_tag_addr;
  logic         cache_tag_en, cache_tag_wmode;
  logic [87:0]  cache_tag_wdata;
  logic [3:0]   cache_tag_wmask;
  logic [8:0]   cache_data_addr;
  logic         cache_data_en, cache_data_wmode;
  logic [255:0] cache_data_wdata;
  logic [31:0]  cache_data_wmask;
  logic [5:0]   tag_RW0_addr;
  logic         tag_RW0_en, tag_RW0_wmode;
  logic [87:0]  tag_RW0_wdata;
  logic [3:0]   tag_RW0_wmask;
  logic [8:0]   data_RW0_addr;
  logic         data_RW0_en, data_RW0_wmode;
  logic [255:0] data_RW0_wdata;
  logic [31:0]  data_RW0_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dcache_inject_ctrl #(.SETS(64), .WAYS(4), .ROWS_PER_SET(8), .TAG_BITS(22), .ROW_BITS(64)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .busy(busy), .done(done), .err(err), .core_hold(core_hold), .checksum(checksum),
    .cache_tag_addr(cache_tag_addr), .cache_tag_en(cache_tag_en), .cache_tag_wmode(cache_tag_wmode),
    .cache_tag_wdata(cache_tag_wdata), .cache_tag_wmask(cache_tag_wmask),
    .cache_data_addr(cache_data_addr), .cache_data_en(cache_data_en), .cache_data_wmode(cache_data_wmode),
    .cache_data_wdata(cache_data_wdata), .cache_data_wmask(cache_data_wmask),
    .tag_RW0_addr(tag_RW0_addr), .tag_RW0_en(tag_RW0_en), .tag_RW0_wmode(tag_RW0_wmode),
    .tag_RW0_wdata(tag_RW0_wdata), .tag_RW0_wmask(tag_RW0_wmask),
    .data_RW0_addr(data_RW0_addr), .data_RW0_en(data_RW0_en), .data_RW0_wmode(data_RW0_wmode),
    .data_RW0_wdata(data_RW0_wdata), .data_RW0_wmask(data_RW0_wmask)
  );

  task automatic randomize_cache_req();
    cache_tag_addr   = 6'($urandom);
    cache_tag_wmode  = 1'($urandom);
    cache_tag_wdata  = {$urandom, $urandom, $urandom};
    cache_tag_wmask  = 4'($urandom);
    cache_data_addr  = 9'($urandom);
    cache_data_wmode = 1'($urandom);
    cache_data_wdata = {8{$urandom}};
    cache_data_wmask = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    randomize_cache_req();
    cache_tag_en = 1'b0; cache_data_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    cache_tag_en = 1'b1; cache_tag_addr = 6'd5; cache_data_en = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, busy, done, err, core_hold} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=00000", {in_ready, busy, done, err, core_hold});
    end
    n_checks++;
    if (checksum !== 64'h0) begin
      n_fail++; $display("FAIL reset_checksum got=%h exp=0", checksum);
    end
    n_checks++;
    if ({tag_RW0_en, tag_RW0_addr, tag_RW0_wmode, tag_RW0_wdata, tag_RW0_wmask} !==
        {1'b1, 6'd5, cache_tag_wmode, cache_tag_wdata, cache_tag_wmask}) begin
      n_fail++; $display("FAIL passthru_tag got en=%b addr=%0d exp en=1 addr=5", tag_RW0_en, tag_RW0_addr);
    end
    n_checks++;
    if ({data_RW0_en, data_RW0_addr, data_RW0_wmode, data_RW0_wdata, data_RW0_wmask} !==
        {1'b1, cache_data_addr, cache_data_wmode, cache_data_wdata, cache_data_wmask}) begin
      n_fail++; $display("FAIL passthru_data got en=%b addr=%0d exp en=1 addr=%0d",
                         data_RW0_en, data_RW0_addr, cache_data_addr);
    end
  endtask

  // vmode: 0 = always valid, 1 = alternate valid, 2 = random valid.
  task automatic run_inject(input int vmode, input int last_at, input int rst_at, input bit chk_timing);
    int sent = 0;
    int cyc = 0;
    int set_i, way, row, idx;
    bit acc;
    bit model_err = 1'b0;
    logic [63:0]  cur;
    logic [63:0]  model_ck = '0;
    logic [63:0]  exp_ck;
    logic [100:0] got_t, exp_t;
    logic [299:0] got_d, exp_d;

    randomize_cache_req();
    cache_tag_en = 1'b1; cache_data_en = 1'b1;
    start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    n_checks++;
    if ({busy, in_ready, core_hold, done, err, checksum} !== {3'b111, 2'b00, 64'h0}) begin
      n_fail++; $display("FAIL after_start got busy=%b done=%b err=%b ck=%h exp busy=1 done=0 err=0 ck=0",
                         busy, done, err, checksum);
    end

    while (sent < 2304 && cyc < 12000) begin
      if (sent == 0) cur = 64'h2ABCD;
      else if (sent == 2303) cur = 64'h0123456789ABCDEF;
      else cur = {$urandom, $urandom};
      case (vmode)
        0: in_valid = 1'b1;
        1: in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_data = cur;
      in_last = (sent == last_at);
      acc = in_valid && in_ready;
      if (sent == rst_at) reset = 1'b1;
      @(posedge clk); #1; cyc++;

      if (reset) begin
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if ({busy, in_ready, core_hold, done, err} !== 5'b0) begin
          n_fail++; $display("FAIL midreset_flags got=%b exp=00000", {busy, in_ready, core_hold, done, err});
        end
        n_checks++;
        if ({tag_RW0_en, tag_RW0_addr, data_RW0_en, data_RW0_addr} !==
            {cache_tag_en, cache_tag_addr, cache_data_en, cache_data_addr}) begin
          n_fail++; $display("FAIL midreset_passthru got tag en=%b a=%0d data en=%b a=%0d exp a=%0d/%0d",
                             tag_RW0_en, tag_RW0_addr, data_RW0_en, data_RW0_addr, cache_tag_addr, cache_data_addr);
        end
        return;
      end

      got_t = {tag_RW0_en, tag_RW0_wmode, tag_RW0_addr, tag_RW0_wmask, tag_RW0_wdata, data_RW0_en};
      got_d = {data_RW0_en, data_RW0_wmode, data_RW0_addr, data_RW0_wmask, data_RW0_wdata, tag_RW0_en};
      if (acc) begin
        if (in_last != (sent == 2303)) model_err = 1'b1;
        if (sent < 256) begin
          model_ck ^= {42'b0, cur[21:0]};
          set_i = sent / 4; way = sent % 4;
          exp_t = {1'b1, 1'b1, 6'(set_i), 4'(1 << way), {4{cur[21:0]}}, 1'b0};
          n_checks++;
          if (got_t !== exp_t) begin
            n_fail++; $display("FAIL tag_write beat %0d got=%h exp=%h", sent, got_t, exp_t);
          end
        end else begin
          model_ck ^= cur;
          idx = sent - 256; row = idx / 4; way = idx % 4;
          exp_d = {1'b1, 1'b1, 9'(row), 32'hFF << (8 * way), {4{cur}}, 1'b0};
          n_checks++;
          if (got_d !== exp_d) begin
            n_fail++; $display("FAIL data_write beat %0d got=%h exp=%h", sent, got_d, exp_d);
          end
        end
        sent++;
      end else begin
        n_checks++;
        if ({tag_RW0_en, data_RW0_en} !== 2'b00) begin
          n_fail++; $display("FAIL bubble beat %0d got en=%b%b exp en=00", sent, tag_RW0_en, data_RW0_en);
        end
      end

`ifdef DCACHE_INJECT_CHECKSUM_EN
      exp_ck = model_ck;
`else
      exp_ck = 64'h0;
`endif
      n_checks++;
      if ({done, busy, in_ready, core_hold, err, checksum} !==
          {sent == 2304, sent < 2304, sent < 2304, sent < 2304, model_err, exp_ck}) begin
        n_fail++; $display("FAIL status beat %0d got done=%b busy=%b err=%b ck=%h exp done=%b err=%b ck=%h",
                           sent, done, busy, err, checksum, sent == 2304, model_err, exp_ck);
      end
    end

    n_checks++;
    if (sent != 2304) begin
      n_fail++; $display("FAIL inject_timeout got beats=%0d exp=2304", sent);
    end
    if (chk_timing) begin
      n_checks++;
      if (cyc + 1 != 2305) begin
        n_fail++; $display("FAIL done_cycle got=%0d exp=2305", cyc + 1);
      end
    end

    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({done, tag_RW0_en, tag_RW0_addr, data_RW0_en, data_RW0_addr} !==
        {1'b1, cache_tag_en, cache_tag_addr, cache_data_en, cache_data_addr}) begin
      n_fail++; $display("FAIL post_done_passthru got done=%b tag en=%b a=%0d data en=%b a=%0d exp a=%0d/%0d",
                         done, tag_RW0_en, tag_RW0_addr, data_RW0_en, data_RW0_addr, cache_tag_addr, cache_data_addr);
    end
  endtask

  task automatic test_back_to_back();  run_inject(0, 2303, -1, 1'b1); endtask
  task automatic test_bubbles();       run_inject(1, 2303, -1, 1'b0); endtask
  task automatic test_last_err();      run_inject(2, 100, -1, 1'b0);  endtask
  task automatic test_reset_mid();     run_inject(0, 2303, 1000, 1'b0); endtask

  task automatic test_checksum();
    logic [63:0] vals [3] = '{64'd1, 64'd2, 64'd4};
    logic [63:0] exp_ck;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    foreach (vals[i]) begin
      in_valid = 1'b1; in_data = vals[i]; in_last = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
`ifdef DCACHE_INJECT_CHECKSUM_EN
    exp_ck = 64'd7;
`else
    exp_ck = 64'd0;
`endif
    n_checks++;
    if (checksum !== exp_ck) begin
      n_fail++; $display("FAIL checksum_3beats got=%h exp=%h", checksum, exp_ck);
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n_checks++;
    if ({checksum, busy} !== 65'h0) begin
      n_fail++; $display("FAIL checksum_reset got ck=%h busy=%b exp ck=0 busy=0", checksum, busy);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_last_err();
    test_reset_mid();
    test_checksum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
